// File: rtl/fractal_pkg.sv
// Shared types and constants for the fractal pixel streamer.
package fractal_pkg;

  localparam int unsigned PIX_W = 24;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/fractal_pixel_fifo.sv
// Synchronous show-ahead FIFO: the head entry is presented on rdata_o whenever empty_o is low.
module fractal_pixel_fifo #(
  parameter  int unsigned DEPTH = 16,
  parameter  int unsigned WIDTH = 24,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Full/empty come from the registered count, so a same-cycle pop never frees a slot for a push.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/fractal_pixel_streamer.sv
// Buffers generator pixel strobes and re-emits them as an AXI4-Stream video frame.
// Define FRAME_CHECKSUM_EN to build the per-frame tdata checksum on frame_checksum.
module fractal_pixel_streamer
  import fractal_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned AF_MARGIN  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] width,
  input  logic [CNT_W-1:0] height,
  input  logic [PIX_W-1:0] pixel_data,
  input  logic             pixel_valid,
  input  logic             gen_done,
  output logic             pix_ready,
  output logic [PIX_W-1:0] m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tuser,
  output logic             m_axis_tlast,
  output logic             frame_done,
  output logic             overflow,
  output logic             short_frame,
  output logic [PIX_W-1:0] frame_checksum
);

  localparam int unsigned CW       = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned AF_LEVEL = FIFO_DEPTH - AF_MARGIN;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] width_q, width_d;
  logic [CNT_W-1:0] height_q, height_d;
  logic [CNT_W-1:0] x_q, x_d;
  logic [CNT_W-1:0] y_q, y_d;
  logic             ovf_q, ovf_d;
  logic             short_q, short_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;

  logic             push;
  logic             pop;
  logic             flush;
  logic             tvalid;
  logic             last_x;
  logic             last_pix;
  logic [PIX_W-1:0] fifo_rdata;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic [CW-1:0]    count_next;

  fractal_pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PIX_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush_i (flush),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (pixel_data),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign tvalid     = ((state_q == STREAM) || (state_q == DRAIN)) && !fifo_empty;
  assign pop        = tvalid && m_axis_tready;
  assign last_x     = (x_q == (width_q - 1'b1));
  assign last_pix   = last_x && (y_q == (height_q - 1'b1));
  assign count_next = fifo_count + CW'(push) - CW'(pop);

  assign m_axis_tvalid = tvalid;
  assign m_axis_tdata  = tvalid ? fifo_rdata : '0;
  assign m_axis_tuser  = tvalid && (x_q == '0) && (y_q == '0);
  assign m_axis_tlast  = tvalid && last_x;
  assign pix_ready     = ready_q;
  assign frame_done    = done_q;
  assign overflow      = ovf_q;
  assign short_frame   = short_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      width_q  <= '0;
      height_q <= '0;
      x_q      <= '0;
      y_q      <= '0;
      ovf_q    <= 1'b0;
      short_q  <= 1'b0;
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      width_q  <= width_d;
      height_q <= height_d;
      x_q      <= x_d;
      y_q      <= y_d;
      ovf_q    <= ovf_d;
      short_q  <= short_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    width_d  = width_q;
    height_d = height_q;
    x_d      = x_q;
    y_d      = y_q;
    ovf_d    = ovf_q;
    short_d  = short_q;
    push     = 1'b0;
    flush    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          width_d  = width;
          height_d = height;
          x_d      = '0;
          y_d      = '0;
          ovf_d    = 1'b0;
          short_d  = 1'b0;
          state_d  = ((width == '0) || (height == '0)) ? DONE : STREAM;
        end
      end
      STREAM: begin
        if (pixel_valid) begin
          if (fifo_full) ovf_d = 1'b1;
          else           push  = 1'b1;
        end
        if (gen_done) state_d = DRAIN;
        // Anything still buffered past the final pixel is surplus and gets discarded.
        if (pop && last_pix) begin
          state_d = DONE;
          if (count_next != '0) ovf_d = 1'b1;
        end
      end
      DRAIN: begin
        if (pixel_valid) ovf_d = 1'b1;
        if (pop && last_pix) begin
          state_d = DONE;
          if (count_next != '0) ovf_d = 1'b1;
        end else if (fifo_empty) begin
          short_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        flush   = 1'b1;
        if (pixel_valid) ovf_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      if (last_x) begin
        x_d = '0;
        y_d = y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  // pix_ready tracks the occupancy the FIFO will hold after this edge.
  assign ready_d = (state_d == STREAM) && (count_next < CW'(AF_LEVEL));
  assign done_d  = (state_d == DONE);

`ifdef FRAME_CHECKSUM_EN
  logic [PIX_W-1:0] csum_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         csum_q <= '0;
    else if ((state_q == IDLE) && start) csum_q <= '0;
    else if (pop)                      csum_q <= csum_q + fifo_rdata;
  end

  assign frame_checksum = csum_q;
`else
  assign frame_checksum = '0;
`endif

endmodule

// File: tb/tb_fractal_pixel_streamer.sv
// Table-driven and randomized frame tests for fractal_pixel_streamer against a beat-list model.
`timescale 1ns/1ps
module tb_fractal_pixel_streamer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] width;
  logic [15:0] height;
  logic [23:0] pixel_data;
  logic        pixel_valid;
  logic        gen_done;
  logic        pix_ready;
  logic [23:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tuser;
  logic        m_axis_tlast;
  logic        frame_done;
  logic        overflow;
  logic        short_frame;
  logic [23:0] frame_checksum;

  fractal_pixel_streamer dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .width          (width),
    .height         (height),
    .pixel_data     (pixel_data),
    .pixel_valid    (pixel_valid),
    .gen_done       (gen_done),
    .pix_ready      (pix_ready),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tuser   (m_axis_tuser),
    .m_axis_tlast   (m_axis_tlast),
    .frame_done     (frame_done),
    .overflow       (overflow),
    .short_frame    (short_frame),
    .frame_checksum (frame_checksum)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          w;
    int          h;
    int          npix;
    bit          send_done;
    bit          honour;
    bit          rnd;
    bit          restart;
    int          stall;
    int          abort_at;
    logic [23:0] first;
    logic [23:0] base;
    int          exp_beats;
    bit          exp_ovf;
    bit          exp_short;
    int          exp_max_occ;
  } case_t;

  case_t       tbl[$];
  logic [23:0] pix [0:1023];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic case_t mk(input int w, input int h, input int npix, input bit sd,
                               input bit honour, input bit rnd, input bit restart,
                               input int stall, input int abort_at, input logic [23:0] first,
                               input logic [23:0] base, input int eb, input bit eo,
                               input bit es, input int occ);
    case_t c;
    c.w = w; c.h = h; c.npix = npix; c.send_done = sd; c.honour = honour; c.rnd = rnd;
    c.restart = restart; c.stall = stall; c.abort_at = abort_at; c.first = first;
    c.base = base; c.exp_beats = eb; c.exp_ovf = eo; c.exp_short = es; c.exp_max_occ = occ;
    return c;
  endfunction

  function automatic logic [63:0] all_outputs();
    return 64'({pix_ready, m_axis_tdata, m_axis_tvalid, m_axis_tuser, m_axis_tlast,
                frame_done, overflow, short_frame, frame_checksum});
  endfunction

  task automatic run_case(input int r, input case_t c);
    int          sent, beats, last_beat_cyc, occ_max, area;
    bit          done_sent, seen_done, finished;
    logic [23:0] sum;
    logic        tv, tu, tl, fd, pr, rdy;
    logic [23:0] td;

    area = c.w * c.h;
    for (int i = 0; i < c.npix; i++)
      pix[i] = c.rnd ? 24'($urandom) : ((i == 0) ? c.first : c.base + 24'(i));
    sum = '0;
    for (int i = 0; i < c.exp_beats; i++) sum = sum + pix[i];

    sent = 0; beats = 0; last_beat_cyc = -1; occ_max = 0;
    done_sent = 1'b0; seen_done = 1'b0; finished = 1'b0;

    @(negedge clk);
    start = 1'b1; width = 16'(c.w); height = 16'(c.h);
    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      @(negedge clk);
      tv = m_axis_tvalid; td = m_axis_tdata; tu = m_axis_tuser; tl = m_axis_tlast;
      fd = frame_done; pr = pix_ready;
      start = 1'b0; pixel_valid = 1'b0; gen_done = 1'b0;
      if (c.abort_at > 0 && beats == c.abort_at) begin
        reset = 1'b1; m_axis_tready = 1'b0;
        #1;
        chk($sformatf("row%0d outputs_in_reset", r), all_outputs(), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        finished = 1'b1;
      end else if (seen_done) begin
        chk($sformatf("row%0d frame_done_one_cycle", r), 64'(fd), 64'(0));
        chk($sformatf("row%0d idle_ready_valid", r), 64'({pr, tv}), 64'(0));
        finished = 1'b1;
      end else begin
        if (fd) begin
          seen_done = 1'b1;
          chk($sformatf("row%0d beat_count", r), 64'(beats), 64'(c.exp_beats));
          chk($sformatf("row%0d overflow", r), 64'(overflow), 64'(c.exp_ovf));
          chk($sformatf("row%0d short_frame", r), 64'(short_frame), 64'(c.exp_short));
`ifdef FRAME_CHECKSUM_EN
          chk($sformatf("row%0d checksum", r), 64'(frame_checksum), 64'(sum));
`else
          chk($sformatf("row%0d checksum_tied", r), 64'(frame_checksum), 64'(0));
`endif
          if (!c.exp_short)
            chk($sformatf("row%0d done_cycle", r), 64'(cyc),
                64'((area == 0) ? 0 : last_beat_cyc + 1));
          if (c.exp_max_occ >= 0)
            chk($sformatf("row%0d max_occupancy", r), 64'(occ_max), 64'(c.exp_max_occ));
        end
        if (c.restart && cyc == 3) begin
          start = 1'b1; width = 16'd1; height = 16'd1;
        end
        rdy = (cyc < c.stall) ? 1'b0 : (c.rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
        m_axis_tready = rdy;
        if (tv && rdy && beats < 1024) begin
          chk($sformatf("row%0d beat%0d {data,user,last}", r, beats), 64'({td, tu, tl}),
              64'({pix[beats], (beats == 0), ((beats % c.w) == c.w - 1)}));
          beats++;
          last_beat_cyc = cyc;
        end
        if (!seen_done && sent < c.npix && (!c.honour || pr) &&
            (!c.rnd || $urandom_range(0, 2) != 0)) begin
          pixel_valid = 1'b1;
          pixel_data  = pix[sent];
          sent++;
        end else if (!seen_done && c.send_done && !done_sent && sent == c.npix) begin
          gen_done  = 1'b1;
          done_sent = 1'b1;
        end
        if (sent - beats > occ_max) occ_max = sent - beats;
      end
    end
    if (!finished) begin
      errors++;
      $display("FAIL row%0d timeout: got no frame completion, expected frame_done", r);
    end
    start = 1'b0; pixel_valid = 1'b0; gen_done = 1'b0; m_axis_tready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; width = '0; height = '0; pixel_data = '0;
    pixel_valid = 1'b0; gen_done = 1'b0; m_axis_tready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", all_outputs(), 64'(0));
    reset = 1'b0;

    //        w  h  n  sd hon rnd rs stall ab first     base      beats ovf sh occ
    tbl.push_back(mk(4, 2,  8, 0, 1, 0, 0,  0, 0, 24'h1,      24'h1,    8, 0, 0, -1));
    tbl.push_back(mk(8, 4, 32, 0, 1, 0, 0, 30, 0, 24'h100,    24'h100, 32, 0, 0, 14));
    tbl.push_back(mk(4, 4, 17, 0, 0, 0, 0, 30, 0, 24'h200,    24'h200, 16, 1, 0, -1));
    tbl.push_back(mk(4, 2,  5, 1, 1, 0, 0,  0, 0, 24'h300,    24'h300,  5, 0, 1, -1));
    tbl.push_back(mk(4, 4, 16, 0, 1, 0, 0,  0, 3, 24'h400,    24'h400,  0, 0, 0, -1));
    tbl.push_back(mk(2, 1,  2, 0, 1, 0, 0,  0, 0, 24'hA1,     24'hA1,   2, 0, 0, -1));
    tbl.push_back(mk(2, 2,  4, 0, 1, 0, 0,  0, 0, 24'hFFFFFF, 24'h0,    4, 0, 0, -1));
    tbl.push_back(mk(0, 3,  0, 0, 1, 0, 0,  0, 0, 24'h0,      24'h0,    0, 0, 0, -1));
    tbl.push_back(mk(4, 2,  8, 0, 1, 0, 1,  2, 0, 24'h500,    24'h500,  8, 0, 0, -1));
    for (int k = 0; k < 6; k++) begin
      int w, h, n;
      bit full;
      w    = $urandom_range(1, 6);
      h    = $urandom_range(1, 4);
      full = ($urandom_range(0, 1) == 1);
      n    = full ? w * h : $urandom_range(0, w * h - 1);
      tbl.push_back(mk(w, h, n, !full, 1, 1, 0, $urandom_range(0, 5), 0, 24'h0, 24'h0,
                       n, 0, !full, -1));
    end

    foreach (tbl[i]) run_case(i, tbl[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
